multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 15, maximum wait cycles for mem_ready before fault (0 = timeout disabled).
REQ-002 SHALL have ports, clock and reset first (one clock; reset is asynchronous and active-low):
  clk  input  1  sole clock, rising edge.
  rst_n  input  1  asynchronous active-low reset.
  run  input  1  permits new instruction fetch.
  opcode  input  4  instruction register opcode field.
  zero  input  1  ALU zero flag.
  mem_ready  input  1  memory completes current access this cycle.
  mem_read, mem_write  output  1  memory strobes.
  i_or_d  output  1  address select: 0 = PC, 1 = ALU out.
  ir_write, pc_write, reg_write  output  1  register write enables.
  reg_dst, mem_to_reg, alu_src_a  output  1  datapath mux selects.
  alu_src_b  output  2  00 = reg B, 01 = const 1, 10 = sign-ext imm, 11 = branch offset.
  alu_op  output  2  00 = add, 01 = sub, 10 = funct, 11 = opcode.
  pc_src  output  1  0 = ALU result, 1 = ALU out register.
  instr_done  output  1  one-cycle pulse on instruction retire.
  fault  output  1  sticky fault flag.
  fault_code  output  2  01 = illegal opcode, 10 = memory timeout.

Function
REQ-003 SHALL classify opcodes: 0000 R-type; 0001, 0010, 0011, 0100, 0111, 1111 I-arith; 0101 beq; 0110 bne; 1000 lw; 1001 sw; 1010-1110 illegal.
REQ-004 SHALL implement states FETCH, DECODE, EXEC_R, EXEC_I, ADDR, BRANCH, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, FAULT.
REQ-005 FETCH: with run=1, SHALL assert mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00; in the cycle mem_ready=1, SHALL also assert ir_write and pc_write and go to DECODE; with run=0, SHALL assert no strobes and hold.
REQ-006 DECODE: SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00 for one cycle, then go to EXEC_R, EXEC_I, ADDR, or BRANCH by class; illegal opcode goes to FAULT with fault_code=01.
REQ-007 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10, then WB_R. EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11, then WB_I.
REQ-008 ADDR: alu_src_a=1, alu_src_b=10, alu_op=00, then MEM_RD (lw) or MEM_WR (sw).
REQ-009 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1; pc_write=zero for beq, pc_write=~zero for bne; then FETCH.
REQ-010 MEM_RD and MEM_WR: SHALL hold mem_read or mem_write with i_or_d=1 until mem_ready=1; MEM_RD then goes to WB_MEM, MEM_WR then goes to FETCH.
REQ-011 WB_R: reg_write=1, reg_dst=1. WB_I: reg_write=1, reg_dst=0. WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0. Each then goes to FETCH.
REQ-012 Any output not listed for a state SHALL be 0.
REQ-013 instr_done SHALL pulse in the last cycle of BRANCH, MEM_WR (on mem_ready), WB_R, WB_I, and WB_MEM.
REQ-014 Latencies with zero-wait memory SHALL be: branch 3 cycles; R, I-arith, and sw 4 cycles; lw 5 cycles.
REQ-015 The wait counter SHALL clear on entry to FETCH, MEM_RD, and MEM_WR, and increment each cycle mem_ready=0 while a strobe is asserted; reaching TIMEOUT_CYCLES SHALL go to FAULT with fault_code=10.
REQ-016 mem_ready and the timeout in the same cycle SHALL resolve in favour of mem_ready.
REQ-017 run=0 mid-instruction SHALL NOT abort the instruction; it is checked only in FETCH.
REQ-018 FAULT SHALL be terminal: all strobes 0, fault=1, fault_code held, until reset.

Reset
REQ-019 rst_n=0 SHALL immediately force state FETCH, counter 0, fault=0, fault_code=00, and every output 0, regardless of run.
REQ-020 Reset mid-memory-access SHALL drop the strobe in the same cycle; after rst_n rises, a fetch begins on the first clock edge with run=1.

Structure
REQ-021 Shared package mips_ctrl_pkg SHALL hold opcode constants, state encoding, alu_op/alu_src_b encodings, and fault codes.
REQ-022 A combinational sub-module mc_opclass_decode SHALL map opcode to a one-hot class vector (r, iarith, beq, bne, lw, sw, illegal).

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  R-type 0000, mem_ready tied 1 -> 4 cycles FETCH, DECODE, EXEC_R, WB_R; reg_write and reg_dst high in cycle 4; instr_done pulse in cycle 4.
  lw 1000, mem_ready low 3 cycles in MEM_RD -> mem_read and i_or_d held 4 cycles; WB_MEM mem_to_reg=1; total 8 cycles.
  beq 0101 with zero=1, then bne 0110 with zero=1 -> pc_write=1 in BRANCH for beq only.
  Opcode 1011 -> FAULT after DECODE with fault_code=01; strobes stay 0 for 20 cycles.
  TIMEOUT_CYCLES=15, mem_ready held 0 in FETCH -> FAULT, fault_code=10, after 15 wait cycles; mem_ready on cycle 15 -> no fault.
  rst_n low during MEM_WR -> mem_write drops without a clock edge; run=0 after reset -> no mem_read.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-style control unit.
package mips_ctrl_pkg;

  // Opcode field values
  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_IA_1 = 4'b0001;
  localparam logic [3:0] OP_IA_2 = 4'b0010;
  localparam logic [3:0] OP_IA_3 = 4'b0011;
  localparam logic [3:0] OP_IA_4 = 4'b0100;
  localparam logic [3:0] OP_BEQ  = 4'b0101;
  localparam logic [3:0] OP_BNE  = 4'b0110;
  localparam logic [3:0] OP_IA_7 = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_IA_F = 4'b1111;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC_R = 4'd2,
    ST_EXEC_I = 4'd3,
    ST_ADDR   = 4'd4,
    ST_BRANCH = 4'd5,
    ST_MEM_RD = 4'd6,
    ST_MEM_WR = 4'd7,
    ST_WB_R   = 4'd8,
    ST_WB_I   = 4'd9,
    ST_WB_MEM = 4'd10,
    ST_FAULT  = 4'd11
  } state_e;

  // ALU operation select
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_OPCODE = 2'b11;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG_B = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BOFF  = 2'b11;

  // Fault codes
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // One-hot instruction class
  typedef struct packed {
    logic r;
    logic iarith;
    logic beq;
    logic bne;
    logic lw;
    logic sw;
    logic illegal;
  } opclass_t;

endpackage

// File: rtl/mc_opclass_decode.sv
// Combinational opcode classifier: exactly one class bit is set for any opcode.
module mc_opclass_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output opclass_t   opclass
);

  // Map opcode to its one-hot class; anything unlisted is illegal
  always_comb begin
    opclass = '0;
    case (opcode)
      OP_R:    opclass.r = 1'b1;
      OP_IA_1,
      OP_IA_2,
      OP_IA_3,
      OP_IA_4,
      OP_IA_7,
      OP_IA_F: opclass.iarith = 1'b1;
      OP_BEQ:  opclass.beq = 1'b1;
      OP_BNE:  opclass.bne = 1'b1;
      OP_LW:   opclass.lw = 1'b1;
      OP_SW:   opclass.sw = 1'b1;
      default: opclass.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM with memory wait timeout and sticky fault.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+1 on mem_ready (idle while run=0)
// DECODE | compute branch target, dispatch by opcode class
// EXEC_R | ALU on reg A, reg B with funct
// EXEC_I | ALU on reg A, sign-extended immediate with opcode
// ADDR   | effective address = reg A + immediate
// BRANCH | compare A-B, conditionally load PC from ALU out
// MEM_RD | data read at ALU out, wait for mem_ready
// MEM_WR | data write at ALU out, wait for mem_ready
// WB_R   | write ALU out to rd
// WB_I   | write ALU out to rt
// WB_MEM | write memory data to rt
// FAULT  | terminal until reset
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_src,
  output logic       instr_done,
  output logic       fault,
  output logic [1:0] fault_code
);

  // The counter never has to hold TIMEOUT_CYCLES itself: the last legal
  // value is TIMEOUT_CYCLES-1, at which a further miss faults instead.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fault_code_q, fault_code_d;
  opclass_t         opclass;
  logic             to_hit;

  mc_opclass_decode u_opclass (
    .opcode  (opcode),
    .opclass (opclass)
  );

  // mem_ready wins over an expiring timeout in the same cycle
  assign to_hit     = TO_EN && (cnt_q == TO_LAST) && !mem_ready;
  assign fault_code = fault_code_q;

  // Next state, wait counter and Moore/Mealy outputs; all outputs forced low in reset
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fault_code_d = fault_code_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_or_d       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_REG_B;
    alu_op       = ALU_ADD;
    pc_src       = 1'b0;
    instr_done   = 1'b0;
    fault        = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          if (run) begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_ONE;
            if (mem_ready) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
              state_d  = ST_DECODE;
            end else if (to_hit) begin
              state_d      = ST_FAULT;
              fault_code_d = FAULT_TIMEOUT;
            end
          end
        end
        ST_DECODE: begin
          alu_src_b = SRCB_BOFF;
          if (opclass.r)                    state_d = ST_EXEC_R;
          else if (opclass.iarith)          state_d = ST_EXEC_I;
          else if (opclass.lw || opclass.sw) state_d = ST_ADDR;
          else if (opclass.beq || opclass.bne) state_d = ST_BRANCH;
          else begin
            state_d      = ST_FAULT;
            fault_code_d = FAULT_ILLEGAL;
          end
        end
        ST_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
          state_d   = ST_WB_R;
        end
        ST_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_OPCODE;
          state_d   = ST_WB_I;
        end
        ST_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = opclass.lw ? ST_MEM_RD : ST_MEM_WR;
        end
        ST_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_src     = 1'b1;
          pc_write   = opclass.bne ? ~zero : zero;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) state_d = ST_WB_MEM;
          else if (to_hit) begin
            state_d      = ST_FAULT;
            fault_code_d = FAULT_TIMEOUT;
          end
        end
        ST_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end else if (to_hit) begin
            state_d      = ST_FAULT;
            fault_code_d = FAULT_TIMEOUT;
          end
        end
        ST_WB_R: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_WB_I: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_FAULT: fault = 1'b1;
        default:  state_d = ST_FETCH;
      endcase
      if (state_d != state_q) begin
        cnt_d = '0;
      end else if (TO_EN && (mem_read || mem_write) && !mem_ready) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State, wait counter and latched fault code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      cnt_q        <= '0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fault_code_q <= fault_code_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors against hand-built tables.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, pc_src, instr_done, fault;
  logic [1:0] alu_src_b, alu_op, fault_code;

  int checks = 0;
  int fails  = 0;

  multicycle_ctrl #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .instr_done(instr_done), .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // {mr,mw,iod,irw,pcw,rw,rd,mtr,asa,asb[2],aop[2],pcs,done,flt,fc[2]}
  logic [17:0] obs;
  assign obs = {mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
                instr_done, fault, fault_code};

  localparam logic [17:0] E_IDLE       = 18'b0;
  localparam logic [17:0] E_FETCH_WAIT = {9'b100_000_000, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] E_FETCH_DONE = {9'b100_110_000, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] E_DECODE     = {9'b000_000_000, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] E_EXEC_R     = {9'b000_000_001, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] E_EXEC_I     = {9'b000_000_001, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] E_ADDR       = {9'b000_000_001, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] E_BR_TAKEN   = {9'b000_010_001, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00};
  localparam logic [17:0] E_BR_NOT     = {9'b000_000_001, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00};
  localparam logic [17:0] E_MEM_RD     = {9'b101_000_000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] E_MWR_WAIT   = {9'b011_000_000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] E_MWR_DONE   = {9'b011_000_000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00};
  localparam logic [17:0] E_WB_R       = {9'b000_001_100, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00};
  localparam logic [17:0] E_WB_I       = {9'b000_001_000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00};
  localparam logic [17:0] E_WB_MEM     = {9'b000_001_010, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00};
  localparam logic [17:0] E_FAULT_ILL  = {9'b000_000_000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01};
  localparam logic [17:0] E_FAULT_TO   = {9'b000_000_000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b10};

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      #1; checks++;
      if (obs !== E_IDLE) begin
        fails++; $display("FAIL reset_hold cyc%0d obs=%b exp=%b", i, obs, E_IDLE);
      end
      @(negedge clk);
    end
    rst_n = 1'b1; run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1; checks++;
      if (obs !== E_IDLE) begin
        fails++; $display("FAIL reset_run0 cyc%0d obs=%b exp=%b", i, obs, E_IDLE);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_r_type();
    logic [17:0] exp [4] = '{E_FETCH_DONE, E_DECODE, E_EXEC_R, E_WB_R};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      run = 1'b1; opcode = 4'b0000; mem_ready = 1'b1;
      #1; checks++;
      if (obs !== exp[i]) begin
        fails++; $display("FAIL r_type cyc%0d obs=%b exp=%b", i + 1, obs, exp[i]);
      end
    end
  endtask

  task automatic test_i_type();
    logic [17:0] exp [4] = '{E_FETCH_DONE, E_DECODE, E_EXEC_I, E_WB_I};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run = 1'b1; opcode = 4'b0111; mem_ready = 1'b1;
      #1; checks++;
      if (obs !== exp[i]) begin
        fails++; $display("FAIL i_type cyc%0d obs=%b exp=%b", i + 1, obs, exp[i]);
      end
    end
  endtask

  task automatic test_lw();
    logic [17:0] exp [8] = '{E_FETCH_DONE, E_DECODE, E_ADDR, E_MEM_RD,
                             E_MEM_RD, E_MEM_RD, E_MEM_RD, E_WB_MEM};
    logic        mr  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      run = 1'b1; opcode = 4'b1000; mem_ready = mr[i];
      #1; checks++;
      if (obs !== exp[i]) begin
        fails++; $display("FAIL lw cyc%0d obs=%b exp=%b", i + 1, obs, exp[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic [17:0] exp [4] = '{E_FETCH_DONE, E_DECODE, E_ADDR, E_MWR_DONE};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run = 1'b1; opcode = 4'b1001; mem_ready = 1'b1;
      #1; checks++;
      if (obs !== exp[i]) begin
        fails++; $display("FAIL sw cyc%0d obs=%b exp=%b", i + 1, obs, exp[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [3:0]  ops [4] = '{4'b0101, 4'b0110, 4'b0101, 4'b0110};
    logic        zs  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [17:0] ebr [4] = '{E_BR_TAKEN, E_BR_NOT, E_BR_NOT, E_BR_TAKEN};
    logic [17:0] exp;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        run = 1'b1; opcode = ops[b]; zero = zs[b]; mem_ready = 1'b1;
        exp = (i == 0) ? E_FETCH_DONE : (i == 1) ? E_DECODE : ebr[b];
        #1; checks++;
        if (obs !== exp) begin
          fails++;
          $display("FAIL branch op=%b zero=%b cyc%0d obs=%b exp=%b",
                   ops[b], zs[b], i + 1, obs, exp);
        end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_run_mid();
    logic [17:0] exp [6] = '{E_FETCH_DONE, E_DECODE, E_EXEC_R, E_WB_R, E_IDLE, E_IDLE};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run = (i == 0); opcode = 4'b0000; mem_ready = 1'b1;
      #1; checks++;
      if (obs !== exp[i]) begin
        fails++; $display("FAIL run_mid cyc%0d obs=%b exp=%b", i + 1, obs, exp[i]);
      end
    end
  endtask

  task automatic test_timeout_edge();
    logic [17:0] exp;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      run = 1'b1; opcode = 4'b0000; mem_ready = (i >= 14);
      exp = (i < 14) ? E_FETCH_WAIT : (i == 14) ? E_FETCH_DONE :
            (i == 15) ? E_DECODE : (i == 16) ? E_EXEC_R : E_WB_R;
      #1; checks++;
      if (obs !== exp) begin
        fails++; $display("FAIL timeout_edge cyc%0d obs=%b exp=%b", i + 1, obs, exp);
      end
    end
  endtask

  task automatic test_timeout();
    logic [17:0] exp;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      run = 1'b1; opcode = 4'b0000; mem_ready = (i >= 16);
      exp = (i < 15) ? E_FETCH_WAIT : E_FAULT_TO;
      #1; checks++;
      if (obs !== exp) begin
        fails++; $display("FAIL timeout cyc%0d obs=%b exp=%b", i + 1, obs, exp);
      end
    end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; run = 1'b0;
    #1; checks++;
    if (obs !== E_IDLE) begin
      fails++; $display("FAIL timeout_clear obs=%b exp=%b", obs, E_IDLE);
    end
  endtask

  task automatic test_illegal();
    logic [17:0] exp;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      run = 1'b1; opcode = 4'b1011; mem_ready = (i < 2) ? 1'b1 : i[0];
      exp = (i == 0) ? E_FETCH_DONE : (i == 1) ? E_DECODE : E_FAULT_ILL;
      #1; checks++;
      if (obs !== exp) begin
        fails++; $display("FAIL illegal cyc%0d obs=%b exp=%b", i + 1, obs, exp);
      end
    end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; run = 1'b0;
    #1; checks++;
    if (obs !== E_IDLE) begin
      fails++; $display("FAIL illegal_clear obs=%b exp=%b", obs, E_IDLE);
    end
  endtask

  task automatic test_reset_mem_wr();
    logic [17:0] exp [4] = '{E_FETCH_DONE, E_DECODE, E_ADDR, E_MWR_WAIT};
    logic [17:0] pexp [8] = '{E_IDLE, E_IDLE, E_IDLE, E_FETCH_WAIT,
                              E_FETCH_DONE, E_DECODE, E_EXEC_R, E_WB_R};
    logic        prst [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        prun [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        pmr  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run = 1'b1; opcode = 4'b1001; mem_ready = (i == 0);
      #1; checks++;
      if (obs !== exp[i]) begin
        fails++; $display("FAIL rst_mwr_pre cyc%0d obs=%b exp=%b", i + 1, obs, exp[i]);
      end
    end
    #1 rst_n = 1'b0;
    #1; checks++;
    if (mem_write !== 1'b0 || obs !== E_IDLE) begin
      fails++; $display("FAIL rst_mwr_drop mem_write=%b obs=%b exp=%b", mem_write, obs, E_IDLE);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst_n = prst[i]; run = prun[i]; opcode = 4'b0000; mem_ready = pmr[i];
      #1; checks++;
      if (obs !== pexp[i]) begin
        fails++; $display("FAIL rst_mwr_post cyc%0d obs=%b exp=%b", i + 1, obs, pexp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_i_type();
    test_lw();
    test_sw();
    test_branch();
    test_run_mid();
    test_timeout_edge();
    test_timeout();
    test_illegal();
    test_reset_mem_wr();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired obs=%b", obs);
    $fatal(1, "bench did not complete");
  end

endmodule
